usb_ep_tx_feeder: RTL and testbench

Streaming front-end for one IN endpoint of the `usb` core. It accepts a byte stream with valid/ready handshaking and packs it into EPDW-wide words on the core's TX EP-buffer write port. Packet boundaries come from `s_last` or from reaching MAX_PKT bytes. For each packet it arms the buffer descriptor through the core's 16-bit bus, then polls that descriptor until the core reports the packet sent. It sits between application logic and the `usb` core's `ep_tx_*` / `wb_*` ports.

---
 rtl/usb_ep_pkg.sv | 25 ++
 rtl/usb_ep_feeder_bus.sv | 54 +++++
 rtl/usb_ep_tx_feeder.sv | 224 ++++++++++++++++++++++
 tb/tb_usb_ep_tx_feeder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
// Shared definitions for the usb IN-endpoint TX feeder: descriptor field layout,
// descriptor state encodings and the feeder FSM state type.
package usb_ep_pkg;

    localparam int BD_STATE_MSB = 15;
    localparam int BD_STATE_LSB = 13;
    localparam int BD_LEN_W     = 10;

    localparam logic [2:0] BD_TX_VALID = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARM,
        ST_WAIT,
        ST_POLL,
        ST_NEXT
    } feeder_state_t;

    // Descriptor word 0 handing a packet of len bytes to the core.
    function automatic logic [15:0] bd_arm_word(input logic [BD_LEN_W-1:0] len);
        return {BD_TX_VALID, 3'b000, len};
    endfunction

endpackage

// File: rtl/usb_ep_feeder_bus.sv
// Single-request master for the core's 16-bit descriptor bus. A request is
// latched when no cycle is open; cycle fields stay frozen until wb_ack.
module usb_ep_feeder_bus (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [15:0] rdata,
    output logic [11:0] wb_addr,
    output logic [15:0] wb_wdata,
    input  logic [15:0] wb_rdata,
    output logic        wb_we,
    output logic        wb_cyc,
    input  logic        wb_ack
);

    logic        cyc_reg;
    logic        we_reg;
    logic [11:0] addr_reg;
    logic [15:0] wdata_reg;
    logic        launch;

    // A launch is only considered while cyc_reg is low, and cyc_reg clears on the
    // ack edge, so back-to-back requests always see at least one idle cycle.
    assign launch = req && !cyc_reg;
    assign done   = cyc_reg && wb_ack;
    assign rdata  = wb_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (done) begin
            cyc_reg <= 1'b0;
            we_reg  <= 1'b0;
        end else if (launch) begin
            cyc_reg   <= 1'b1;
            we_reg    <= we;
            addr_reg  <= addr;
            wdata_reg <= wdata;
        end
    end

    assign wb_cyc   = cyc_reg;
    assign wb_we    = we_reg;
    assign wb_addr  = addr_reg;
    assign wb_wdata = wdata_reg;

endmodule

// File: rtl/usb_ep_tx_feeder.sv
// Byte-stream front-end for one usb IN endpoint: packs bytes into EP buffer words,
// arms the descriptor and polls it until sent. Optional zero-length packet: USB_EP_TX_FEEDER_ZLP_EN.
module usb_ep_tx_feeder
    import usb_ep_pkg::*;
#(
    parameter int          EPDW     = 32,
    parameter int          EPAW     = 8,
    parameter int          BUF_BASE = 0,
    parameter logic [11:0] BD_ADDR  = 12'h800,
    parameter int          MAX_PKT  = 64,
    parameter int          POLL_DLY = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      s_data,
    input  logic            s_valid,
    input  logic            s_last,
    output logic            s_ready,
    output logic [EPAW-1:0] ep_tx_addr_0,
    output logic [EPDW-1:0] ep_tx_data_0,
    output logic            ep_tx_we_0,
    output logic [11:0]     wb_addr,
    output logic [15:0]     wb_wdata,
    input  logic [15:0]     wb_rdata,
    output logic            wb_we,
    output logic            wb_cyc,
    input  logic            wb_ack,
    output logic            busy,
    output logic            pkt_sent
);

    localparam int DLYW = (POLL_DLY < 2) ? 1 : $clog2(POLL_DLY);

    feeder_state_t state_reg, state_next;

    logic [9:0]      byte_cnt_reg;
    logic [10:0]     cnt_inc;
    logic            last_reg;
    logic            s_ready_reg;
    logic            busy_reg;
    logic            pkt_sent_reg;
    logic            we_reg;
    logic [EPAW-1:0] addr_reg;
    logic [EPDW-1:0] data_reg;
    logic [DLYW-1:0] dly_cnt_reg;

    logic            accept;
    logic            pkt_end;
    logic            poll_idle;
    logic            bd_valid;
    logic            zlp_due;
    logic            zlp_active;

    logic            bus_req;
    logic            bus_we;
    logic [9:0]      arm_len;
    logic [15:0]     bus_wdata;
    logic            bus_done;
    logic [15:0]     bus_rdata;
    logic            rdata_unused;

    assign accept    = s_valid && s_ready_reg;
    assign cnt_inc   = {1'b0, byte_cnt_reg} + 11'd1;
    assign pkt_end   = s_last || (cnt_inc == 11'(MAX_PKT));
    assign poll_idle = (dly_cnt_reg == DLYW'(POLL_DLY - 1));
    assign bd_valid  = (bus_rdata[BD_STATE_MSB:BD_STATE_LSB] == BD_TX_VALID);
    // Only the descriptor state field matters when polling.
    assign rdata_unused = ^bus_rdata[BD_STATE_LSB-1:0];

`ifdef USB_EP_TX_FEEDER_ZLP_EN
    logic full_reg;
    logic zlp_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            zlp_reg  <= 1'b0;
        end else begin
            if (accept && pkt_end) begin
                full_reg <= (cnt_inc == 11'(MAX_PKT));
            end
            if (state_reg == ST_NEXT) begin
                zlp_reg <= zlp_due;
            end
        end
    end

    // A transfer ending on a full packet needs a trailing zero-length packet.
    assign zlp_due    = last_reg && full_reg && !zlp_reg;
    assign zlp_active = zlp_reg;
`else
    assign zlp_due    = 1'b0;
    assign zlp_active = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = pkt_end ? ST_ARM : ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept && pkt_end) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (bus_done) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (poll_idle) begin
                    state_next = ST_POLL;
                end
            end
            ST_POLL: begin
                if (bus_done) begin
                    state_next = bd_valid ? ST_WAIT : ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (zlp_due) begin
                    state_next = ST_ARM;
                end else if (last_reg) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Requests are raised on the transition edge so the bus cycle opens in the
    // first cycle of ARM/POLL; while the cycle is open the bus ignores req.
    always_comb begin
        bus_req   = (state_next == ST_ARM) || (state_next == ST_POLL);
        bus_we    = (state_next == ST_ARM);
        arm_len   = (state_reg == ST_NEXT) ? 10'd0 : cnt_inc[9:0];
        bus_wdata = bd_arm_word(arm_len);
    end

    usb_ep_feeder_bus u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus_req),
        .we       (bus_we),
        .addr     (BD_ADDR),
        .wdata    (bus_wdata),
        .done     (bus_done),
        .rdata    (bus_rdata),
        .wb_addr  (wb_addr),
        .wb_wdata (wb_wdata),
        .wb_rdata (wb_rdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_reg <= '0;
            last_reg     <= 1'b0;
            s_ready_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            pkt_sent_reg <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            dly_cnt_reg  <= '0;
        end else begin
            we_reg       <= 1'b0;
            pkt_sent_reg <= 1'b0;
            s_ready_reg  <= (state_next == ST_IDLE) || (state_next == ST_FILL);

            if (accept) begin
                data_reg[{byte_cnt_reg[1:0], 3'b000} +: 8] <= s_data;
                byte_cnt_reg <= cnt_inc[9:0];
                last_reg     <= s_last;
                busy_reg     <= 1'b1;
                if ((byte_cnt_reg[1:0] == 2'd3) || pkt_end) begin
                    we_reg   <= 1'b1;
                    addr_reg <= EPAW'(BUF_BASE) + EPAW'(byte_cnt_reg[9:2]);
                end
            end

            if (state_reg == ST_NEXT) begin
                byte_cnt_reg <= '0;
                if (state_next == ST_IDLE) begin
                    busy_reg <= 1'b0;
                end
            end

            if (state_reg == ST_POLL && bus_done && !bd_valid && !zlp_active) begin
                pkt_sent_reg <= 1'b1;
            end

            if (state_reg == ST_WAIT) begin
                dly_cnt_reg <= dly_cnt_reg + DLYW'(1);
            end else begin
                dly_cnt_reg <= '0;
            end
        end
    end

    assign s_ready      = s_ready_reg;
    assign ep_tx_we_0   = we_reg;
    assign ep_tx_addr_0 = addr_reg;
    assign ep_tx_data_0 = data_reg;
    assign busy         = busy_reg;
    assign pkt_sent     = pkt_sent_reg;

endmodule

// File: tb/tb_usb_ep_tx_feeder.sv
// Scoreboard bench for usb_ep_tx_feeder: a packet model fills expectation queues,
// a monitor pops and compares them, and a bus responder plays the usb core.
module tb_usb_ep_tx_feeder;

    localparam int          MAX_PKT  = 8;
    localparam int          POLL_DLY = 4;
    localparam int          BUF_BASE = 16;
    localparam logic [11:0] BD_ADDR  = 12'h800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  ep_tx_addr_0;
    logic [31:0] ep_tx_data_0;
    logic        ep_tx_we_0;
    logic [11:0] wb_addr;
    logic [15:0] wb_wdata;
    logic [15:0] wb_rdata = '0;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack = 1'b0;
    logic        busy;
    logic        pkt_sent;

    usb_ep_tx_feeder #(
        .EPDW(32), .EPAW(8), .BUF_BASE(BUF_BASE), .BD_ADDR(BD_ADDR),
        .MAX_PKT(MAX_PKT), .POLL_DLY(POLL_DLY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .ep_tx_addr_0(ep_tx_addr_0), .ep_tx_data_0(ep_tx_data_0), .ep_tx_we_0(ep_tx_we_0),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .busy(busy), .pkt_sent(pkt_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] mask;
    } wr_t;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0]  tx_bytes[$];
    wr_t         exp_wr[$];
    logic [15:0] exp_arm[$];
    int          exp_sent_total = 0;
    int          got_sent_total = 0;

    int ack_delay_force = 0;
    int poll_force      = -1;
    int poll_plan       = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: split the transfer into MAX_PKT chunks, words of 4 bytes.
    task automatic model_push();
        int n;
        int start;
        int len;
        wr_t e;
        n = tx_bytes.size();
        start = 0;
        len = 0;
        while (start < n) begin
            len = (n - start > MAX_PKT) ? MAX_PKT : n - start;
            for (int w = 0; w * 4 < len; w++) begin
                e.addr = 8'(BUF_BASE + w);
                e.data = '0;
                e.mask = '0;
                for (int k = 0; k < 4 && w * 4 + k < len; k++) begin
                    e.data[8*k +: 8] = tx_bytes[start + 4*w + k];
                    e.mask[8*k +: 8] = 8'hff;
                end
                exp_wr.push_back(e);
            end
            exp_arm.push_back({3'b001, 3'b000, 10'(len)});
            exp_sent_total++;
            start += len;
        end
`ifdef USB_EP_TX_FEEDER_ZLP_EN
        if (len == MAX_PKT) exp_arm.push_back(16'h2000);
`endif
    endtask

    // Drives tx_bytes; with do_last the final byte carries s_last.
    task automatic drive_bytes(input bit do_last, input bit gaps);
        int t;
        for (int i = 0; i < tx_bytes.size(); i++) begin
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            s_data  = tx_bytes[i];
            s_last  = do_last && (i == tx_bytes.size() - 1);
            s_valid = 1'b1;
            t = 0;
            forever begin
                @(negedge clk);
                if (s_ready) break;
                t++;
                if (t > 1000) begin
                    check(1'b0, "s_ready_timeout", 32'(t), 32'd1000);
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
            if (i == 0) check(busy == 1'b1, "busy_rise", 32'(busy), 32'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (busy) begin
            @(posedge clk); #1;
            t++;
            if (t > 3000) begin
                check(1'b0, "busy_timeout", 32'(t), 32'd3000);
                break;
            end
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        check(s_ready == 1'b1, "idle_ready", 32'(s_ready), 32'd1);
        check(exp_wr.size() == 0, "words_left", 32'(exp_wr.size()), 32'd0);
        check(exp_arm.size() == 0, "arms_left", 32'(exp_arm.size()), 32'd0);
        check(got_sent_total == exp_sent_total, "pkt_sent_count", 32'(got_sent_total), 32'(exp_sent_total));
    endtask

    task automatic run_transfer(input bit gaps);
        model_push();
        drive_bytes(1'b1, gaps);
        wait_done();
    endtask

    task automatic check_all_zero(input string tag);
        check({s_ready, ep_tx_we_0, wb_we, wb_cyc, busy, pkt_sent} == 6'b0, tag,
              32'({s_ready, ep_tx_we_0, wb_we, wb_cyc, busy, pkt_sent}), 32'd0);
        check(ep_tx_data_0 == 32'd0 && ep_tx_addr_0 == 8'd0, "reset_ep", ep_tx_data_0, 32'd0);
        check(wb_addr == 12'd0 && wb_wdata == 16'd0, "reset_wb", {wb_addr, 4'h0, wb_wdata}, 32'd0);
    endtask

    // Bus responder standing in for the usb core.
    initial begin : responder
        int wait_cnt;
        int polls_left;
        bit in_cyc;
        wait_cnt = 0;
        polls_left = 0;
        in_cyc = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                wb_ack = 1'b0;
                in_cyc = 1'b0;
            end else if (wb_ack) begin
                wb_ack = 1'b0;
            end else if (wb_cyc) begin
                if (!in_cyc) begin
                    in_cyc = 1'b1;
                    wait_cnt = (wb_we && ack_delay_force > 0) ? ack_delay_force : int'($urandom_range(0, 2));
                end
                if (wait_cnt == 0) begin
                    wb_ack = 1'b1;
                    in_cyc = 1'b0;
                    if (wb_we) begin
                        poll_plan  = (poll_force >= 0) ? poll_force : int'($urandom_range(0, 2));
                        polls_left = poll_plan;
                        wb_rdata   = 16'($urandom);
                    end else if (polls_left > 0) begin
                        polls_left--;
                        wb_rdata = {3'b001, 13'($urandom)};
                    end else begin
                        wb_rdata = {3'($urandom_range(2, 7)), 13'($urandom)};
                    end
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write, ack or pulse.
    initial begin : monitor
        int pos, idle_run, reads;
        bit we_next, cyc_next, sent_next, had_cycle, prev_cyc, prev_we, cur_zlp;
        bit hold_wait, ready_hi;
        bit chk_we, chk_cyc, chk_sent, last;
        logic [11:0] prev_addr;
        logic [15:0] prev_wdata;
        wr_t e;
        logic [15:0] a;
        pos = 0; idle_run = 0; reads = 0;
        we_next = 0; cyc_next = 0; sent_next = 0; had_cycle = 0; prev_cyc = 0; prev_we = 0;
        cur_zlp = 0; hold_wait = 0; ready_hi = 0;
        prev_addr = '0; prev_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pos = 0; idle_run = 0; reads = 0;
                we_next = 0; cyc_next = 0; sent_next = 0; had_cycle = 0; prev_cyc = 0;
                cur_zlp = 0; hold_wait = 0; ready_hi = 0;
                continue;
            end
            chk_we = we_next; chk_cyc = cyc_next; chk_sent = sent_next;
            we_next = 0; cyc_next = 0; sent_next = 0;

            if (chk_we || ep_tx_we_0) check(ep_tx_we_0 == chk_we, "we_timing", 32'(ep_tx_we_0), 32'(chk_we));
            if (ep_tx_we_0) begin
                if (exp_wr.size() == 0) begin
                    check(1'b0, "unexpected_word", ep_tx_data_0, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check(ep_tx_addr_0 == e.addr, "word_addr", 32'(ep_tx_addr_0), 32'(e.addr));
                    check((ep_tx_data_0 & e.mask) == e.data, "word_data", ep_tx_data_0 & e.mask, e.data);
                end
            end
            if (chk_cyc) check(wb_cyc && wb_we, "arm_latency", {30'd0, wb_cyc, wb_we}, 32'd3);

            if (wb_cyc && !prev_cyc) begin
                if (had_cycle) check(idle_run >= 1, "bus_gap", 32'(idle_run), 32'd1);
                if (had_cycle && !wb_we) check(idle_run >= POLL_DLY, "poll_gap", 32'(idle_run), 32'(POLL_DLY));
                had_cycle = 1;
            end
            if (wb_cyc && prev_cyc) begin
                check(wb_addr == prev_addr && wb_wdata == prev_wdata && wb_we == prev_we, "bus_stable",
                      {wb_addr, wb_we, 3'b0, wb_wdata}, {prev_addr, prev_we, 3'b0, prev_wdata});
            end
            idle_run = wb_cyc ? 0 : idle_run + 1;
            prev_cyc = wb_cyc; prev_addr = wb_addr; prev_wdata = wb_wdata; prev_we = wb_we;

            if (wb_cyc && wb_ack) begin
                check(wb_addr == BD_ADDR, "bd_addr", 32'(wb_addr), 32'(BD_ADDR));
                if (wb_we) begin
                    if (exp_arm.size() == 0) begin
                        check(1'b0, "unexpected_arm", 32'(wb_wdata), 32'd0);
                    end else begin
                        a = exp_arm.pop_front();
                        check(wb_wdata == a, "arm_word", 32'(wb_wdata), 32'(a));
                    end
                    cur_zlp = (wb_wdata[9:0] == 10'd0);
                    reads = 0;
                end else begin
                    reads++;
                    if (wb_rdata[15:13] != 3'b001) begin
                        check(reads == poll_plan + 1, "poll_reads", 32'(reads), 32'(poll_plan + 1));
                        sent_next = !cur_zlp;
                    end
                end
            end

            if (chk_sent || pkt_sent) check(pkt_sent == chk_sent, "pkt_sent_timing", 32'(pkt_sent), 32'(chk_sent));
            if (hold_wait && s_ready) ready_hi = 1;
            if (pkt_sent) begin
                got_sent_total++;
                if (hold_wait) check(!ready_hi, "ready_hold", 32'(ready_hi), 32'd0);
                hold_wait = 0;
            end

            if (s_valid && s_ready) begin
                last = s_last || (pos == MAX_PKT - 1);
                we_next = ((pos % 4) == 3) || last;
                pos = last ? 0 : pos + 1;
                if (last) begin
                    cyc_next = 1;
                    hold_wait = 1;
                    ready_hi = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_ctrl");
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single packet 01..05.
        tx_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_transfer(1'b0);

        // Split transfer: 20 bytes -> 8, 8, 4.
        tx_bytes.delete();
        for (int i = 0; i < 20; i++) tx_bytes.push_back(8'($urandom));
        run_transfer(1'b0);

        // Polling: three VALID replies before completion.
        poll_force = 3;
        tx_bytes = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_transfer(1'b0);
        poll_force = -1;

        // Backpressure on the ARM write.
        ack_delay_force = 10;
        tx_bytes = {8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6};
        run_transfer(1'b1);
        ack_delay_force = 0;

        // Abort mid-packet with an asynchronous reset.
        tx_bytes = {8'hc1, 8'hc2, 8'hc3};
        drive_bytes(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort_ctrl");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        tx_bytes = {8'hbe, 8'hef};
        run_transfer(1'b0);

        // Boundary lengths: exactly one and two full packets, single byte.
        for (int k = 0; k < 3; k++) begin
            n = (k == 0) ? MAX_PKT : (k == 1) ? 2 * MAX_PKT : 1;
            tx_bytes.delete();
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
            run_transfer(1'b1);
        end

        // Randomized transfers.
        for (int k = 0; k < 15; k++) begin
            n = $urandom_range(1, 21);
            tx_bytes.delete();
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
            ack_delay_force = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 8)) : 0;
            run_transfer($urandom_range(0, 1) == 1);
        end
        ack_delay_force = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
